// File: rtl/uart_pkg.sv
// Shared constants for the UART debug-print path.
//   ASCII_*  : fixed characters used around the hex digits
//   state_t  : hex printer FSM states
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit encoder.
//   i_nibble : 4-bit value 0..15
//   o_ascii  : '0'..'9', then 'A'..'F' (UPPERCASE != 0) or 'a'..'f'
import uart_pkg::*;

module nibble_to_ascii #(
  parameter int unsigned UPPERCASE = 1
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nibble};
    end else begin
      o_ascii = ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'h0, i_nibble};
    end
  end

endmodule

// File: rtl/uart_hex_printer.sv
// Formats a 32-bit value as ASCII hex ("0x" digits CR LF, each part optional)
// and writes it byte by byte into the UART transmitter FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   print_req         : start request, accepted only when idle
//   print_value       : value to print, captured on acceptance
//   busy, done        : busy from acceptance to done; done is a 1-cycle pulse
//   fifo_ready        : transmitter FIFO can take a byte (one cycle stale)
//   start_uart        : 1-cycle write strobe
//   uart_tx_data      : byte written while start_uart is high
import uart_pkg::*;

module uart_hex_printer #(
  parameter int unsigned NIBBLES    = 8,
  parameter int unsigned PREFIX_EN  = 1,
  parameter int unsigned NEWLINE_EN = 1,
  parameter int unsigned UPPERCASE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        print_req,
  input  logic [31:0] print_value,
  output logic        busy,
  output logic        done,
  input  logic        fifo_ready,
  output logic        start_uart,
  output logic [7:0]  uart_tx_data
);

  localparam int unsigned PFX = (PREFIX_EN != 0) ? 2 : 0;
  localparam int unsigned NL  = (NEWLINE_EN != 0) ? 2 : 0;
  localparam int unsigned N   = PFX + NIBBLES + NL;
  localparam int unsigned IW  = $clog2(N + 1);

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_value;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_start, w_start_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            w_load;
  logic [3:0]      w_nib;
  logic [7:0]      w_ascii;
  logic [7:0]      w_byte;

  // Digit position j (0 = most significant printed nibble) lives at idx PFX+j.
  always_comb begin
    w_nib = '0;
    for (int unsigned j = 0; j < NIBBLES; j++) begin
      if (r_idx == IW'(PFX + j)) begin
        w_nib = r_value[(NIBBLES - 1 - j) * 4 +: 4];
      end
    end
  end

  nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nib (
    .i_nibble(w_nib),
    .o_ascii (w_ascii)
  );

  always_comb begin
    w_byte = w_ascii;
    if (PREFIX_EN != 0 && r_idx == IW'(0)) begin
      w_byte = ASCII_0;
    end else if (PREFIX_EN != 0 && r_idx == IW'(1)) begin
      w_byte = ASCII_X;
    end else if (NEWLINE_EN != 0 && r_idx == IW'(PFX + NIBBLES)) begin
      w_byte = ASCII_CR;
    end else if (NEWLINE_EN != 0 && r_idx == IW'(PFX + NIBBLES + 1)) begin
      w_byte = ASCII_LF;
    end
  end

  // Next-state logic. The mandatory GAP after every write limits the rate to
  // one byte per two clocks, which hides the staleness of fifo_ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (print_req) w_state_nxt = ST_EMIT;
      ST_EMIT: if (fifo_ready) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = (r_idx == IW'(N)) ? ST_FIN : ST_EMIT;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; everything is registered below.
  always_comb begin
    w_load      = 1'b0;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_start_nxt = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (print_req) begin
          w_load     = 1'b1;
          w_idx_nxt  = '0;
          w_busy_nxt = 1'b1;
        end
      end
      ST_EMIT: begin
        if (fifo_ready) begin
          w_start_nxt = 1'b1;
          w_data_nxt  = w_byte;
          w_idx_nxt   = r_idx + IW'(1);
        end
      end
      ST_FIN: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_value <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_value <= print_value;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_start <= w_start_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign start_uart   = r_start;
  assign uart_tx_data = r_data;

endmodule

// File: tb/tb_uart_hex_printer.sv
module tb_uart_hex_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: default parameters. B: 4 lowercase digits, no prefix, no newline.
  logic        rst_a, req_a, busy_a, done_a, rdy_a, start_a;
  logic [31:0] val_a;
  logic [7:0]  data_a;
  logic        rst_b, req_b, busy_b, done_b, rdy_b, start_b;
  logic [31:0] val_b;
  logic [7:0]  data_b;

  uart_hex_printer dut_a (
    .clk(clk), .rst(rst_a), .print_req(req_a), .print_value(val_a),
    .busy(busy_a), .done(done_a), .fifo_ready(rdy_a),
    .start_uart(start_a), .uart_tx_data(data_a)
  );

  uart_hex_printer #(
    .NIBBLES(4), .PREFIX_EN(0), .NEWLINE_EN(0), .UPPERCASE(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .print_req(req_b), .print_value(val_b),
    .busy(busy_b), .done(done_b), .fifo_ready(rdy_b),
    .start_uart(start_b), .uart_tx_data(data_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int issued_a = 0, aborted_a = 0, dones_a = 0, strobes_a = 0, exp_end_a = 0;
  int exp_busy_a = 0, busy_cnt_a = 0;
  int issued_b = 0, dones_b = 0, strobes_b = 0, exp_end_b = 0;
  logic rdy_s_a = 1'b0;
  logic prev_start_a = 1'b0, prev_start_b = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  // Reference text: "0x" + 8 uppercase digits + CR LF.
  function automatic void push_a(logic [31:0] v);
    string hx = "0123456789ABCDEF";
    sb_a.push_back(8'h30);
    sb_a.push_back(8'h78);
    for (int i = 7; i >= 0; i--) sb_a.push_back(hx[v[i*4 +: 4]]);
    sb_a.push_back(8'h0D);
    sb_a.push_back(8'h0A);
  endfunction

  // Reference text: 4 lowercase digits of the low 16 bits.
  function automatic void push_b(logic [31:0] v);
    string hx = "0123456789abcdef";
    for (int i = 3; i >= 0; i--) sb_b.push_back(hx[v[i*4 +: 4]]);
  endfunction

  always @(posedge clk) rdy_s_a <= rdy_a;

  // Monitor A
  always @(negedge clk) begin
    if (rst_a) busy_cnt_a = 0;
    else if (busy_a) busy_cnt_a++;
    if (start_a) begin
      check("a_ready_at_write", rdy_s_a, 1);
      check("a_strobe_spacing", prev_start_a, 0);
      if (sb_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_extra_byte: got %02h required no write", data_a);
      end else begin
        check("a_byte", data_a, sb_a.pop_front());
      end
      strobes_a++;
    end
    prev_start_a = start_a;
    if (done_a) begin
      check("a_done_pulse", dones_a + 1, issued_a - aborted_a);
      check("a_byte_count", strobes_a, exp_end_a);
      if (exp_busy_a != 0) check("a_busy_len", busy_cnt_a, exp_busy_a);
      dones_a++;
      busy_cnt_a = 0;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (start_b) begin
      check("b_strobe_spacing", prev_start_b, 0);
      if (sb_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_extra_byte: got %02h required no write", data_b);
      end else begin
        check("b_byte", data_b, sb_b.pop_front());
      end
      strobes_b++;
    end
    prev_start_b = start_b;
    if (done_b) begin
      check("b_done_pulse", dones_b + 1, issued_b);
      check("b_byte_count", strobes_b, exp_end_b);
      dones_b++;
    end
  end

  // All tasks are entered and left #1 after a rising edge.
  task automatic issue_a(input logic [31:0] v, input int busy_len);
    push_a(v);
    exp_end_a  = strobes_a + 12;
    exp_busy_a = busy_len;
    issued_a++;
    req_a = 1'b1; val_a = v;
    @(posedge clk); #1;
    req_a = 1'b0; val_a = $urandom;
  endtask

  task automatic issue_b(input logic [31:0] v);
    push_b(v);
    exp_end_b = strobes_b + 4;
    issued_b++;
    req_b = 1'b1; val_b = v;
    @(posedge clk); #1;
    req_b = 1'b0; val_b = $urandom;
  endtask

  task automatic wait_idle_a(input int budget, input bit rnd);
    int c = 0;
    while ((busy_a || dones_a != issued_a - aborted_a) && c < budget) begin
      if (rnd) rdy_a = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      c++;
    end
    rdy_a = 1'b1;
    if (c >= budget) begin
      n_vec++; n_err++;
      $display("FAIL a_timeout: busy=%0b dones=%0d required idle with %0d dones",
               busy_a, dones_a, issued_a - aborted_a);
    end
  endtask

  task automatic wait_idle_b(input int budget);
    int c = 0;
    while ((busy_b || dones_b != issued_b) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= budget) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: busy=%0b dones=%0d required %0d", busy_b, dones_b, issued_b);
    end
  endtask

  task automatic wait_strobes_a(input int target, input int budget);
    int c = 0;
    while (strobes_a < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= budget) begin
      n_vec++; n_err++;
      $display("FAIL a_strobe_timeout: got %0d strobes required %0d", strobes_a, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int base, cnt;
    bit w, p1, p2;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    val_a = '0;   val_b = '0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    check("a_rst_busy", busy_a, 0);
    check("a_rst_done", done_a, 0);
    check("a_rst_start", start_a, 0);
    check("a_rst_data", data_a, 0);
    check("b_rst_busy", busy_b, 0);
    check("b_rst_start", start_b, 0);

    // 1: DEADBEEF, always ready, busy 2N+1 clocks
    issue_a(32'hDEAD_BEEF, 25);
    wait_idle_a(200, 0);
    exp_busy_a = 0;

    // 2: lowercase 4-digit form
    issue_b(32'h0000_0A9F);
    wait_idle_b(100);

    // 3: FIFO not ready for 10 clocks after the 3rd byte
    base = strobes_a;
    issue_a($urandom, 0);
    wait_strobes_a(base + 3, 50);
    rdy_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("a_stall_no_strobe", strobes_a, base + 3);
    check("a_stall_busy", busy_a, 1);
    rdy_a = 1'b1;
    wait_idle_a(200, 0);

    // 4: 64-deep FIFO with 60 entries, no drain
    cnt = 60;
    base = strobes_a;
    issue_a(32'h1234_5678, 0);
    repeat (40) begin
      @(negedge clk); w = start_a;
      @(posedge clk); #1;
      if (w) begin
        cnt++;
        check("a_fifo_no_overflow", (cnt <= 64) ? 1 : 0, 1);
      end
      rdy_a = (cnt < 64);
    end
    check("a_fifo_accepted", strobes_a, base + 4);
    check("a_fifo_stall_busy", busy_a, 1);
    cnt = 0;
    rdy_a = 1'b1;
    wait_idle_a(200, 0);

    // 5: requests while busy, with a different value, are ignored
    base = strobes_a;
    issue_a($urandom, 0);
    p1 = 0; p2 = 0;
    for (int c = 0; c < 100 && busy_a; c++) begin
      req_a = 1'b0;
      if (!p1 && strobes_a == base + 2) begin req_a = 1'b1; val_a = $urandom; p1 = 1; end
      if (!p2 && strobes_a == base + 7) begin req_a = 1'b1; val_a = $urandom; p2 = 1; end
      @(posedge clk); #1;
    end
    req_a = 1'b0;
    wait_idle_a(200, 0);

    // 6: reset after the 5th byte, then a fresh print
    base = strobes_a;
    issue_a($urandom, 0);
    wait_strobes_a(base + 5, 50);
    rst_a = 1'b1;
    sb_a.delete();
    aborted_a++;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check("a_rst_mid_busy", busy_a, 0);
    check("a_rst_mid_start", start_a, 0);
    check("a_rst_mid_done", done_a, 0);
    repeat (6) @(posedge clk);
    #1;
    check("a_rst_no_more_bytes", strobes_a, base + 5);
    issue_a($urandom, 0);
    wait_idle_a(200, 0);

    // Random values with random FIFO readiness on A, concurrent prints on B
    repeat (16) begin
      issue_a($urandom, 0);
      issue_b($urandom);
      wait_idle_a(400, 1);
      wait_idle_b(100);
    end

    check("a_queue_drained", sb_a.size(), 0);
    check("b_queue_drained", sb_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
